// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO write side: data width, arbiter
// defaults and the write-port arbiter state encoding.
package afifo_pkg;

  localparam int AFIFO_DWIDTH      = 8;
  localparam int ARB_NREQ_DEF      = 4;
  localparam int ARB_MAX_BEATS_DEF = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/afifo_wr_arb_rr_pick.sv
// Combinational round-robin search: first set request at or after start_i,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] rot;
  int             j;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    rot     = {req_i, req_i} >> start_i;
    // Walk from the far end so the offset nearest to start_i wins.
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        j = int'(start_i) + k;
        if (j >= N) j = j - N;
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ producers,
// with packet locking, a MAX_BEATS fairness split and wfull backpressure.
module afifo_wr_arb
  import afifo_pkg::*;
#(
  parameter int NREQ      = ARB_NREQ_DEF,
  parameter int DWIDTH    = AFIFO_DWIDTH,
  parameter int MAX_BEATS = ARB_MAX_BEATS_DEF
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DWIDTH-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     split
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BEATS+1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          locked;
  logic          accept;
  logic          at_max;

  rr_pick #(.N(NREQ), .IW(IW)) u_rr_pick (
    .req_i   (req_valid),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign locked = (state_q == ARB_LOCKED);
  // A beat presented while reset is asserted must never reach the FIFO.
  assign accept = locked & req_valid[grant_q] & ~wfull & ~wrst;
  assign at_max = (beat_cnt_q == LAST_CNT);

  assign req_ready = accept ? (NREQ'(1) << grant_q) : '0;
  assign winc      = accept;
  assign wdata     = locked ? req_data[int'(grant_q)*DWIDTH +: DWIDTH] : '0;
  assign grant_id  = grant_q;
  assign busy      = locked;
  assign split     = accept & ~req_last[grant_q] & at_max;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (req_last[grant_q] || at_max) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (grant_q == IW'(NREQ-1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: doc/afifo_wr_arb.md
# afifo_wr_arb

Round-robin write-port arbiter that shares the single write port of the async FIFO among `NREQ` producers in the write clock domain. Each producer sends packets of one or more beats. A granted producer keeps the port until its last beat, or until a fairness limit of `MAX_BEATS` beats forces a split. The block sits directly in front of the FIFO write interface and obeys `wfull` backpressure so the FIFO never overflows.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DWIDTH`, 8: data width; must equal the FIFO data width.
- `MAX_BEATS`, 16: beats per grant before a forced release, ≥1.

Ports:
- `wclk` in 1: write-domain clock. This is the only clock.
- `wrst` in 1: reset, synchronous and active-high.
- `req_valid` in NREQ: per-requester beat valid.
- `req_data` in NREQ*DWIDTH: requester i occupies bits [i*DWIDTH +: DWIDTH].
- `req_last` in NREQ: the beat presented is the last beat of its packet.
- `req_ready` out NREQ: beat accepted this cycle. One-hot or zero.
- `wfull` in 1: FIFO full flag, already synchronised into `wclk`.
- `winc` out 1: FIFO write enable.
- `wdata` out DWIDTH: FIFO write data.
- `grant_id` out $clog2(NREQ): current owner. Valid while `busy` is high.
- `busy` out 1: a grant is held.
- `split` out 1: one-cycle pulse when a grant is force-released by `MAX_BEATS`.

## Operation
- FSM states: IDLE and LOCKED.
- IDLE:
  - If any `req_valid` is high, pick the winner by round-robin. Search starts at `rr_ptr` and wraps modulo `NREQ`.
  - Register the winner into `grant_id`, clear `beat_cnt`, and go to LOCKED.
  - No beat transfers in IDLE.
- LOCKED:
  - `req_ready[grant_id] = req_valid[grant_id] & ~wfull`. All other `req_ready` bits are 0.
  - `winc = req_ready[grant_id]`; `wdata = req_data[grant_id]`. Both are combinational.
  - Each accepted beat increments `beat_cnt`, which has width $clog2(MAX_BEATS+1).
  - Release to IDLE on the cycle after either of these:
    - an accepted beat with `req_last` high, or
    - an accepted beat that makes `beat_cnt == MAX_BEATS` with `req_last` low. In this case `split` pulses in that same cycle.
  - On release, `rr_ptr <= (grant_id+1) mod NREQ`.
  - If the owner drops `req_valid` mid-packet, the grant is held: no timeout, and `winc` stays 0.
- `wfull` high: no accept and no count. The state and the grant are unchanged.
- A packet that is last on the `MAX_BEATS`-th beat releases normally, with no `split`.
- After a forced split, the remainder of the packet re-arbitrates like any new request.
- A requester that is not granted sees `req_ready=0` and must hold its data. The arbiter never drops a beat.

## Timing
- Reset values:
  - outputs: `winc=0`, `req_ready=0`, `busy=0`, `split=0`, `grant_id=0`, `wdata=0`;
  - internal: state IDLE, `rr_ptr=0` (requester 0 has highest priority), `beat_cnt=0`.
- Reset mid-packet abandons the grant immediately. Any beat presented in the reset cycle is not written.
- Arbitration latency is one cycle. With a request in IDLE at cycle t, the first beat can transfer at t+1.
- Throughput is one beat per cycle while LOCKED and `wfull` is low. There is one bubble cycle per grant.
- `wfull` is sampled combinationally. A beat is never accepted in a cycle where `wfull` is high.
- `busy` is high exactly when the state is LOCKED. `grant_id` is stable for the whole LOCKED period.

## Structure
- Shared package `afifo_pkg` holds:
  - the FSM state enum `arb_state_e {ARB_IDLE, ARB_LOCKED}`;
  - the localparam defaults for `NREQ` and `MAX_BEATS`, next to the existing FIFO data-width define.
- Natural sub-module: `rr_pick`. It is combinational and takes a request vector plus a start pointer, and returns a found flag plus an index.
- Estimated size is about 150–220 lines of RTL in total.

## Test plan
- Single packet, no backpressure:
  - Stimulus: requester 2 sends beats 0xA1,0xA2,0xA3 with last on 0xA3.
  - Response: `busy` rises one cycle after the request. `winc` is high for 3 consecutive cycles carrying 0xA1..0xA3. `busy` falls after the last beat. `rr_ptr` becomes 3.
- Round-robin fairness:
  - Stimulus: all 4 requesters send continuous 1-beat packets.
  - Response: grants go in order 0,1,2,3,0,1… and each requester gets exactly 25% of 40 writes.
- Backpressure:
  - Stimulus: `wfull` is high for 5 cycles in the middle of a 4-beat packet from requester 1.
  - Response: `winc=0` and `req_ready=0` for those 5 cycles. All 4 beats reach the FIFO in order with no duplicates. `beat_cnt` is frozen while `wfull` is high.
- Forced split:
  - Stimulus: `MAX_BEATS=4`; requester 0 sends a 10-beat packet while requester 3 is waiting.
  - Response: `split` pulses after beat 4. Requester 3's packet is written. Requester 0 then resumes at beat 5.
- Reset mid-packet:
  - Stimulus: `wrst` is asserted for 1 cycle on beat 2 of a 5-beat packet.
  - Response: all outputs are 0 in the next cycle and `busy=0`. After reset, requester 0 has priority and the bench-side scoreboard sees no beat from the reset cycle.
- Owner stall:
  - Stimulus: the owner drops `req_valid` for 3 cycles mid-packet while others are requesting.
  - Response: the grant is held, `winc=0` during the stall, and no other `req_ready` bit rises.
